// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box table, xtime helper and key-schedule FSM state type
package aes_pkg;
  localparam int DATA_W = 128;
  localparam int NR = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if: key-load request and round-key valid/ready bundle
//   master (consumer side): drives key_load, key_in, key_ready
//   slave  (key expander):  drives round_key, round_idx, key_valid_out, busy, done
interface aes_key_expand_if;
  import aes_pkg::*;
  logic key_load;
  logic [DATA_W-1:0] key_in;
  logic key_ready;
  logic [DATA_W-1:0] round_key;
  logic [3:0] round_idx;
  logic key_valid_out;
  logic busy;
  logic done;
  modport master (
    output key_load, key_in, key_ready,
    input round_key, round_idx, key_valid_out, busy, done
  );
  modport slave (
    input key_load, key_in, key_ready,
    output round_key, round_idx, key_valid_out, busy, done
  );
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box lookup
//   a: input byte, y: substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 on-the-fly key schedule emitting round keys 0..NR over valid/ready
//   clk: rising-edge clock, reset: synchronous active-low
//   bus: slave side of aes_key_expand_if (key load in, tagged round keys out)
module aes_key_expand
  import aes_pkg::*;
(
  input logic clk,
  input logic reset,
  aes_key_expand_if.slave bus
);
  state_t state;
  logic [DATA_W-1:0] key_q;
  logic [3:0] idx_q;
  logic [7:0] rcon;
  logic valid_q, busy_q, done_q;
  logic [31:0] rot, sub, t, n0, n1, n2, n3;
  assign rot = {key_q[23:0], key_q[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  assign t = sub ^ {rcon, 24'h0};
  assign n0 = key_q[127:96] ^ t;
  assign n1 = key_q[95:64] ^ n0;
  assign n2 = key_q[63:32] ^ n1;
  assign n3 = key_q[31:0] ^ n2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      key_q <= '0;
      idx_q <= '0;
      rcon <= AES_RCON_INIT;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.key_load) begin
          state <= RUN;
          key_q <= bus.key_in;
          idx_q <= '0;
          rcon <= AES_RCON_INIT;
          valid_q <= 1'b1;
          busy_q <= 1'b1;
        end
      end else if (valid_q && bus.key_ready) begin
        if (idx_q == 4'(NR)) begin
          state <= IDLE;
          valid_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          key_q <= {n0, n1, n2, n3};
          idx_q <= idx_q + 4'd1;
          rcon <= xtime(rcon);
        end
      end
    end
  end
  assign bus.round_key = key_q;
  assign bus.round_idx = idx_q;
  assign bus.key_valid_out = valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: randomized scoreboard bench for aes_key_expand against a GF(2^8)-derived key schedule model
module tb_aes_key_expand;
  localparam logic [127:0] A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  typedef struct {
    logic [127:0] key;
    logic [3:0] idx;
    logic [127:0] base;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  aes_key_expand_if bus();
  aes_key_expand dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  bit m_busy = 0, m_done = 0, m_rst = 0, armed = 0;
  int m_idx = 0;
  bit rnd_ready = 0;
  int stall_n = 0;
  bit prev_stall = 0;
  logic [127:0] prev_key;
  logic [3:0] prev_idx;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
    r = inv;
    s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s ^= r;
    end
    return s ^ 8'h63;
  endfunction
  function automatic void push_sched(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_q.push_back('{{w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, 4'(r), k});
  endfunction
  always @(posedge clk) begin
    m_done = 0;
    if (!reset) begin
      m_busy = 0;
      m_idx = 0;
      m_rst = 1;
      armed = 1;
      exp_q.delete();
    end else begin
      m_rst = 0;
      if (!m_busy) begin
        if (bus.key_load) begin
          push_sched(bus.key_in);
          m_busy = 1;
          m_idx = 0;
        end
      end else if (bus.key_ready) begin
        if (m_idx == 10) begin
          m_busy = 0;
          m_done = 1;
        end else m_idx++;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      chk("valid", {127'b0, bus.key_valid_out}, {127'b0, m_busy});
      chk("busy", {127'b0, bus.busy}, {127'b0, m_busy});
      chk("done", {127'b0, bus.done}, {127'b0, m_done});
      if (m_rst) begin
        chk("rst_key", bus.round_key, 128'h0);
        chk("rst_idx", {124'b0, bus.round_idx}, 128'h0);
      end else if (prev_stall) begin
        chk("stall_key", bus.round_key, prev_key);
        chk("stall_idx", {124'b0, bus.round_idx}, {124'b0, prev_idx});
      end
      if (bus.key_valid_out && bus.key_ready && reset) begin
        if (exp_q.size() == 0) chk("unexpected_key", {124'b0, bus.round_idx}, 128'hffff);
        else begin
          e = exp_q.pop_front();
          chk("round_idx", {124'b0, bus.round_idx}, {124'b0, e.idx});
          chk("round_key", bus.round_key, e.key);
          if (e.base == A1 && e.idx == 4'd1) chk("kat_a1_1", bus.round_key, A1_1);
          if (e.base == A1 && e.idx == 4'd10) chk("kat_a1_10", bus.round_key, A1_10);
          if (e.base == 128'h0 && e.idx == 4'd1) chk("kat_z_1", bus.round_key, Z_1);
          if (e.base == 128'h0 && e.idx == 4'd10) chk("kat_z_10", bus.round_key, Z_10);
        end
      end
      prev_stall = bus.key_valid_out && !bus.key_ready && reset;
      prev_key = bus.round_key;
      prev_idx = bus.round_idx;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    if (stall_n > 0) begin
      bus.key_ready = 1'b0;
      stall_n--;
    end else bus.key_ready = rnd_ready ? ($urandom_range(2) != 0) : 1'b1;
  endtask
  task automatic timeout(input string n);
    checks++;
    failures++;
    $display("FAIL %s timeout", n);
  endtask
  task automatic start(input logic [127:0] k);
    bus.key_in = k;
    bus.key_load = 1'b1;
    cyc();
    bus.key_load = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 300) begin cyc(); n++; end
    if (m_busy) timeout("wait_idle");
  endtask
  task automatic wait_idx(input int i);
    int n = 0;
    while (!(m_busy && m_idx == i) && n < 300) begin cyc(); n++; end
    if (n >= 300) timeout("wait_idx");
  endtask
  task automatic wait_done();
    int n = 0;
    while (!m_done && n < 300) begin cyc(); n++; end
    if (!m_done) timeout("wait_done");
  endtask
  task automatic rand_key(output logic [127:0] k);
    k = {$urandom, $urandom, $urandom, $urandom};
  endtask
  initial begin
    logic [127:0] k;
    bus.key_load = 1'b0;
    bus.key_in = '0;
    bus.key_ready = 1'b1;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    start(A1);
    wait_idle();
    start(128'h0);
    wait_idle();
    rnd_ready = 1;
    start(A1);
    wait_idx(4);
    stall_n = 3;
    wait_idle();
    rnd_ready = 0;
    start(A1);
    wait_idx(5);
    rand_key(k);
    bus.key_in = k;
    bus.key_load = 1'b1;
    cyc();
    bus.key_load = 1'b0;
    wait_done();
    rand_key(k);
    start(k);
    wait_idle();
    rand_key(k);
    start(k);
    wait_idx(6);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    start(A1);
    wait_idle();
    rnd_ready = 1;
    for (int j = 0; j < 4; j++) begin
      rand_key(k);
      start(k);
      wait_done();
      rand_key(k);
      start(k);
      wait_idle();
    end
    repeat (3) cyc();
    chk("queue_empty", 128'(exp_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- AES-128 key schedule stage that feeds AddRoundKey.
- Accepts a 128-bit cipher key and emits round keys 0..10 one at a time, in order, over a valid/ready handshake.
- Each key is tagged with its round index, so the datapath can pair it with the matching state word.
- Computes round keys on the fly: one key register plus one S-box word per step, no key RAM.

Parameters:
- DATA_W, 128, key and round-key width; only 128 is supported.
- NR, 10, number of rounds; last emitted round_idx equals NR.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- key_load  in  1  request to start a schedule with key_in.
- key_in  in  DATA_W  cipher key; FIPS-197 byte order, byte 0 in [127:120].
- key_ready  in  1  consumer accepts round_key this cycle.
- round_key  out  DATA_W  current round key.
- round_idx  out  4  index of round_key, 0..NR.
- key_valid_out  out  1  round_key/round_idx are valid.
- busy  out  1  a schedule is in progress.
- done  out  1  one-cycle pulse after round NR is accepted.

Behaviour:
- Reset is sampled on posedge clk while low. All outputs go to 0 (round_key, round_idx, key_valid_out, busy, done). FSM goes to IDLE and the Rcon register goes to 8'h01.
- Reset mid-schedule aborts immediately. The next key must be reloaded.
- FSM states: IDLE, RUN.
- IDLE:
  - key_load=1 at edge N loads key_in into round_key.
  - Same edge: round_idx=0, key_valid_out=1, busy=1, Rcon=8'h01, state moves to RUN.
  - Round key 0 is therefore visible at cycle N+1 (latency 1).
- RUN, handshake = key_valid_out && key_ready:
  - No handshake: round_key, round_idx and key_valid_out hold stable, whatever the stall length.
  - Handshake with round_idx<NR: next edge loads the next round key, increments round_idx, and updates Rcon to xtime(Rcon). key_valid_out stays 1. Throughput is one key per cycle under continuous ready.
  - Handshake with round_idx==NR: next edge clears key_valid_out and busy, pulses done=1 for one cycle, and returns to IDLE. round_key and round_idx keep their last values.
- key_load while busy=1 is ignored; no restart.
- key_load in the same cycle that done is high is accepted, since the FSM is already in IDLE. Back-to-back schedules therefore have a 1-cycle bubble.
- key_in is sampled only on the accepting edge.
- Next-key arithmetic:
  - Words are w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}, where RotWord({a,b,c,d})={b,c,d,a}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - All operations are pure XOR/byte ops; there is no carry.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits.
- The next-key path is combinational from the key register. SubWord uses 4 S-box instances.
- done never coincides with key_valid_out=1.

Decomposition:
- Package aes_pkg holds:
  - DATA_W and NR constants;
  - the AES_RCON_INIT=8'h01 constant;
  - the 256-entry S-box table constant, shared with SubBytes;
  - FSM state typedef {IDLE, RUN}.
- One sub-module: aes_sbox. It is a combinational 8-bit in / 8-bit out lookup from the package table, instantiated 4x for SubWord.

Test Plan:
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1.
  - Idx0 = key_in.
  - Idx1 = a0fafe1788542cb123a339392a6c7605.
  - Idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly 1 cycle after idx10 is accepted; 11 valid cycles total.
- All-zero key:
  - Idx1 = 62636363626363636263636362636363.
  - Idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: toggle key_ready randomly (e.g. low 3 cycles at idx4).
  - round_key/round_idx are held bit-stable while stalled.
  - Same 11 keys as the A.1 run, no skips or duplicates.
- key_load pulsed with a different key at idx5 while busy.
  - It is ignored; the sequence finishes with the A.1 values.
  - key_load asserted together with done starts the new schedule; idx0 appears on the next cycle.
- reset low at idx6 for 1 cycle.
  - All outputs are 0 on the next cycle and the FSM is in IDLE.
  - A fresh key_load restarts from idx0 with Rcon=01, giving the correct idx1.
